// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter letting two ports share one data memory, one access per two cycles
module dmem_arbiter #(
    parameter int DEPTH = 128
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_address,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    output logic [31:0] mem_writeData,
    input  logic [31:0] mem_readData
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;
    logic        port_b_q, port_b_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        a_rvalid_q, a_rvalid_d;
    logic        b_rvalid_q, b_rvalid_d;
    logic        err_q, err_d;
    logic        idle, access, in_range, hit, rd_done;
    always_comb begin
        idle          = reset && state_q == IDLE;
        access        = state_q == ACCESS;
        in_range      = addr_q[31:2] < DEPTH_W;
        hit           = access && in_range;
        rd_done       = access && !we_q;
        a_gnt         = idle && a_req && (!b_req || last_b_q);
        b_gnt         = idle && b_req && (!a_req || !last_b_q);
        state_d       = (a_gnt || b_gnt) ? ACCESS : IDLE;
        last_b_d      = a_gnt ? 1'b0 : b_gnt ? 1'b1 : last_b_q;
        port_b_d      = (a_gnt || b_gnt) ? b_gnt : port_b_q;
        we_d          = a_gnt ? a_we : b_gnt ? b_we : we_q;
        addr_d        = a_gnt ? a_addr : b_gnt ? b_addr : addr_q;
        wdata_d       = a_gnt ? a_wdata : b_gnt ? b_wdata : wdata_q;
        rdata_d       = rd_done ? (in_range ? mem_readData : 32'd0) : rdata_q;
        a_rvalid_d    = rd_done && !port_b_q;
        b_rvalid_d    = rd_done && port_b_q;
        err_d         = access && !in_range;
        mem_memWrite  = hit && we_q;
        mem_memRead   = hit && !we_q;
        mem_address   = hit ? addr_q : 32'd0;
        mem_writeData = hit ? wdata_q : 32'd0;
        rdata         = rdata_q;
        a_rvalid      = a_rvalid_q;
        b_rvalid      = b_rvalid_q;
        err           = err_q;
    end
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            port_b_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            port_b_q   <= port_b_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, access timing, range errors and reset abort
module tb_dmem_arbiter;
    logic        clock_in = 1'b0;
    logic        reset = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, err;
    logic [31:0] rdata, mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, mem_memRead;
    logic [31:0] mem [0:127];
    int          errors = 0;
    int          checks = 0;

    dmem_arbiter #(.DEPTH(128)) dut (
        .clock_in(clock_in), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .err(err),
        .mem_address(mem_address), .mem_memWrite(mem_memWrite),
        .mem_memRead(mem_memRead), .mem_writeData(mem_writeData),
        .mem_readData(mem_readData)
    );

    always #5 clock_in = ~clock_in;

    assign mem_readData = mem[mem_address[8:2]];
    always @(negedge clock_in) if (mem_memWrite) mem[mem_address[8:2]] <= mem_writeData;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_rdata", rdata, 0);
        check("rst_valid_err", {a_rvalid, b_rvalid, err}, 0);
        check("rst_mem_ctl", {mem_memWrite, mem_memRead}, 0);
        check("rst_mem_addr", mem_address, 0);
        @(negedge clock_in);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        mem[2] = 32'd2;

        do_reset();
        a_req = 1; a_we = 0; a_addr = 32'h8; #1;
        check("r36_a_gnt", a_gnt, 1);
        check("r36_b_gnt", b_gnt, 0);
        step(); a_req = 0; #1;
        check("r36_acc_rd", mem_memRead, 1);
        check("r36_acc_addr", mem_address, 32'h8);
        check("r36_acc_gnt", a_gnt, 0);
        step();
        check("r36_rvalid", a_rvalid, 1);
        check("r36_rdata", rdata, 2);
        check("r36_err", err, 0);
        check("r36_mem_idle", {mem_memRead, mem_memWrite}, 0);
        step();
        check("r36_rvalid_drop", a_rvalid, 0);
        check("r36_rdata_hold", rdata, 2);

        a_req = 1; b_req = 1; a_addr = 32'h8; b_addr = 32'h8;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            check($sformatf("r37_a_gnt_c%0d", c), a_gnt, (c % 4 == 0) ? 1 : 0);
            check($sformatf("r37_b_gnt_c%0d", c), b_gnt, (c % 4 == 2) ? 1 : 0);
            if (c >= 2) begin
                check($sformatf("r37_a_rv_c%0d", c), a_rvalid, (c % 4 == 2) ? 1 : 0);
                check($sformatf("r37_b_rv_c%0d", c), b_rvalid, (c % 4 == 0) ? 1 : 0);
            end
            step();
        end
        a_req = 0; b_req = 0;

        do_reset();
        b_req = 1; b_we = 1; b_addr = 32'h1C; b_wdata = 32'hDEADBEEF; #1;
        check("r38_b_gnt", b_gnt, 1);
        step(); b_req = 0; #1;
        check("r38_wr", {mem_memWrite, mem_memRead}, 2'b10);
        check("r38_waddr", mem_address, 32'h1C);
        check("r38_wdata", mem_writeData, 32'hDEADBEEF);
        step();
        check("r38_no_rvalid", {a_rvalid, b_rvalid, err}, 0);
        check("r38_mem_model", mem[7], 32'hDEADBEEF);
        a_req = 1; a_we = 0; a_addr = 32'h1C; #1;
        check("r38_a_gnt", a_gnt, 1);
        step(); a_req = 0;
        step();
        check("r38_rvalid", a_rvalid, 1);
        check("r38_rdata", rdata, 32'hDEADBEEF);

        a_req = 1; a_we = 0; a_addr = 32'h200; #1;
        check("r39_a_gnt", a_gnt, 1);
        step(); a_req = 0; #1;
        check("r39_no_rd", {mem_memRead, mem_memWrite}, 0);
        step();
        check("r39_rvalid", a_rvalid, 1);
        check("r39_rdata", rdata, 0);
        check("r39_err", err, 1);
        step();
        check("r39_err_drop", err, 0);
        a_req = 1; a_addr = 32'h1F; #1;
        step(); a_req = 0; #1;
        check("r39_lowbits_rd", mem_memRead, 1);
        step();
        check("r39_lowbits_data", rdata, 32'hDEADBEEF);
        check("r39_lowbits_err", err, 0);
        b_req = 1; b_we = 1; b_addr = 32'h400; b_wdata = 32'h1234; #1;
        check("r39_wr_gnt", b_gnt, 1);
        step(); b_req = 0; #1;
        check("r39_wr_blocked", mem_memWrite, 0);
        step();
        check("r39_wr_err", err, 1);
        check("r39_wr_no_rv", b_rvalid, 0);

        do_reset();
        a_req = 1; a_we = 1; a_addr = 32'h4; a_wdata = 32'h55; #1;
        check("r40_a_gnt", a_gnt, 1);
        step(); a_req = 0; #1;
        check("r40_wr_on", mem_memWrite, 1);
        reset = 1'b0; #1;
        check("r40_wr_drop", mem_memWrite, 0);
        a_req = 1; #1;
        check("r40_gnt_in_rst", a_gnt, 0);
        a_req = 0;
        @(negedge clock_in); #1;
        check("r40_mem_kept", mem[1], 0);
        reset = 1'b1;
        step();
        check("r40_no_rv", {a_rvalid, b_rvalid, err}, 0);
        a_req = 1; a_we = 0; a_addr = 32'h8; #1;
        check("r40_idle_gnt", a_gnt, 1);
        a_req = 0;

        a_req = 1; a_we = 0; a_addr = 32'h8;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            check($sformatf("r41_a_gnt_c%0d", c), a_gnt, (c % 2 == 0) ? 1 : 0);
            step();
            if (c == 4) begin
                b_req = 1; b_we = 0; b_addr = 32'h8;
            end
        end
        check("r41_b_wins", b_gnt, 1);
        check("r41_a_loses", a_gnt, 0);
        step(); step();
        check("r41_a_next", a_gnt, 1);
        check("r41_b_rv", b_rvalid, 1);
        a_req = 0; b_req = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
